// File: rtl/aes_spi_master.sv
// -----------------------------------------------------------------------------
// aes_spi_master
//   Serial-link master for the AES Slave. On an accepted start it shifts out one
//   plaintext block followed by the full key frame (LSB first, one bit per clk).
//   It then raises mode for WAIT_CYCLES cycles while the Slave computes, and
//   captures the result from SOMI (LSB first). Finally it pulses done.
//
// Ports
//   clk      in   1      system clock, rising edge
//   reset    in   1      synchronous active-high reset
//   start    in   1      transfer request, sampled only in IDLE
//   msg      in   MSG_W  plaintext block, latched on accepted start
//   key      in   KEY_W  key frame, latched on accepted start
//   size_in  in   2      key size code, latched on accepted start
//   SOMI     in   1      serial data from Slave
//   SIMO     out  1      serial data to Slave
//   CSS      out  1      chip select to Slave, active low
//   mode     out  1      0 = load phase, 1 = Slave output phase
//   size     out  2      latched key size code
//   result   out  MSG_W  captured Slave output, valid with done
//   busy     out  1      accepted start through done cycle inclusive
//   done     out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module aes_spi_master #(
    parameter int MSG_W       = 128,
    parameter int KEY_W       = 256,
    parameter int WAIT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MSG_W-1:0] msg,
    input  logic [KEY_W-1:0] key,
    input  logic [1:0]       size_in,
    input  logic             SOMI,
    output logic             SIMO,
    output logic             CSS,
    output logic             mode,
    output logic [1:0]       size,
    output logic [MSG_W-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int FRAME_W = MSG_W + KEY_W;
    localparam int CNT_A   = $clog2(FRAME_W);
    localparam int CNT_B   = $clog2(WAIT_CYCLES);
    localparam int CNT_W   = (CNT_A > CNT_B) ? CNT_A : CNT_B;
    localparam int RES_IW  = $clog2(MSG_W);

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECV_LAST = CNT_W'(MSG_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               cnt_last_s;
    // Holds the not-yet-sent bits; bit 0 is always the next bit to drive.
    logic [FRAME_W-1:0] frame_r;
    logic               css_s;
    logic               mode_s;
    logic               busy_s;
    logic               done_s;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Detects the final cycle of the current timed phase.
    always_comb begin
        cnt_last_s = 1'b0;
        case (state_r)
            ST_SEND: cnt_last_s = (cnt_r == SEND_LAST);
            ST_WAIT: cnt_last_s = (cnt_r == WAIT_LAST);
            ST_RECV: cnt_last_s = (cnt_r == RECV_LAST);
            default: cnt_last_s = 1'b0;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (cnt_last_s) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (cnt_last_s) begin
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RECV: begin
                if (cnt_last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they are registered
    // yet line up exactly with the state they describe.
    always_comb begin
        css_s  = 1'b1;
        mode_s = 1'b0;
        busy_s = 1'b1;
        done_s = 1'b0;
        case (state_s)
            ST_IDLE: busy_s = 1'b0;
            ST_SEND: css_s  = 1'b0;
            ST_WAIT: begin
                css_s  = 1'b0;
                mode_s = 1'b1;
            end
            ST_RECV: begin
                css_s  = 1'b0;
                mode_s = 1'b1;
            end
            ST_DONE: done_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            CSS  <= 1'b1;
            mode <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            CSS  <= css_s;
            mode <= mode_s;
            busy <= busy_s;
            done <= done_s;
        end
    end

    // Datapath: frame shifter, serial output, phase counter, result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_r <= '0;
            SIMO    <= 1'b0;
            size    <= 2'b00;
            cnt_r   <= CNT_ZERO;
            result  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (start) begin
                        // msg[0] goes straight to the wire so it is present for
                        // all of SEND cycle 0; the shifter keeps the rest.
                        SIMO    <= msg[0];
                        frame_r <= {1'b0, key, msg[MSG_W-1:1]};
                        size    <= size_in;
                    end else begin
                        SIMO <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (cnt_last_s) begin
                        SIMO  <= 1'b0;
                        cnt_r <= CNT_ZERO;
                    end else begin
                        SIMO    <= frame_r[0];
                        frame_r <= {1'b0, frame_r[FRAME_W-1:1]};
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    SIMO <= 1'b0;
                    if (cnt_last_s) begin
                        cnt_r <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RECV: begin
                    SIMO                  <= 1'b0;
                    result[cnt_r[RES_IW-1:0]] <= SOMI;
                    if (cnt_last_s) begin
                        cnt_r <= CNT_ZERO;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    SIMO  <= 1'b0;
                    cnt_r <= CNT_ZERO;
                end
                default: begin
                    SIMO  <= 1'b0;
                    cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_spi_master.sv
// -----------------------------------------------------------------------------
// tb_aes_spi_master
//   Directed self-checking bench. The bench plays the Slave's role on SOMI,
//   driving a known result block during the receive window, and checks the
//   serial stream, phase timing, latency, result capture, busy guard and reset.
// -----------------------------------------------------------------------------
module tb_aes_spi_master;

    localparam int W     = 64;
    localparam int FRAME = 384;
    localparam int LAT   = FRAME + W + 129;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] msg;
    logic [255:0] key;
    logic [1:0]   size_in;
    logic         SOMI;
    logic         SIMO;
    logic         CSS;
    logic         mode;
    logic [1:0]   size;
    logic [127:0] result;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] MSG_A = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] MSG_B = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128  = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [255:0] K192  = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] RES_A = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] RES_B = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] RES_C = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_spi_master #(
        .MSG_W      (128),
        .KEY_W      (256),
        .WAIT_CYCLES(W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .msg    (msg),
        .key    (key),
        .size_in(size_in),
        .SOMI   (SOMI),
        .SIMO   (SIMO),
        .CSS    (CSS),
        .mode   (mode),
        .size   (size),
        .result (result),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transfer. glitch_at > 0 pulses start with altered inputs for one
    // cycle at that post-accept cycle number (cycle 1 = SEND cycle 0).
    task automatic run_xfer(input string tag, input logic [127:0] m, input logic [255:0] k,
                            input logic [1:0] sz, input logic [127:0] res, input int glitch_at);
        logic [383:0] stream;
        logic [383:0] exp_stream;
        int cyc;
        int done_at;
        int ndone;
        int send_bad;
        int win_bad;
        int size_bad;
        int done_bad;
        stream     = '0;
        exp_stream = {k, m};
        cyc = 0; done_at = 0; ndone = 0;
        send_bad = 0; win_bad = 0; size_bad = 0; done_bad = 0;
        @(negedge clk);
        msg = m; key = k; size_in = sz; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        msg = ~m; key = ~k; size_in = ~sz;
        while (cyc < 2000 && (done_at == 0 || cyc < done_at + 3)) begin
            cyc++;
            SOMI = ($urandom_range(0, 1) == 1);
            if (glitch_at > 0 && cyc == glitch_at) begin
                start = 1'b1; msg = ~m; size_in = ~sz;
            end else begin
                start = 1'b0;
            end
            if (busy === 1'b1 && size !== sz) size_bad++;
            if (done === 1'b1) begin
                ndone++;
                if (done_at == 0) done_at = cyc;
                if (busy !== 1'b1 || CSS !== 1'b1 || mode !== 1'b0 || SIMO !== 1'b0) done_bad++;
                check({tag, "_result"}, {256'd0, result}, {256'd0, res});
            end else if (cyc <= FRAME) begin
                stream[cyc-1] = SIMO;
                if (CSS !== 1'b0 || mode !== 1'b0 || busy !== 1'b1) send_bad++;
            end else if (cyc <= FRAME + W) begin
                if (CSS !== 1'b0 || mode !== 1'b1 || SIMO !== 1'b0) win_bad++;
            end else if (cyc <= FRAME + W + 128) begin
                SOMI = res[cyc - FRAME - W - 1];
                if (CSS !== 1'b0 || mode !== 1'b1) win_bad++;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check({tag, "_stream"},   stream, exp_stream);
        check({tag, "_send_sig"}, 384'(send_bad), 384'd0);
        check({tag, "_wait_recv"}, 384'(win_bad), 384'd0);
        check({tag, "_size"},     384'(size_bad), 384'd0);
        check({tag, "_latency"},  384'(done_at), 384'(LAT));
        check({tag, "_done_cnt"}, 384'(ndone), 384'd1);
        check({tag, "_done_sig"}, 384'(done_bad), 384'd0);
        check({tag, "_idle_busy"}, {383'd0, busy}, 384'd0);
        check({tag, "_held"},     {256'd0, result}, {256'd0, res});
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; msg = MSG_A; key = K128; size_in = 2'b10; SOMI = 1'b0;
        // Reset with start asserted must hold the idle values.
        repeat (2) @(posedge clk);
        #1;
        check("rst_css",    {383'd0, CSS},  384'd1);
        check("rst_mode",   {383'd0, mode}, 384'd0);
        check("rst_busy",   {383'd0, busy}, 384'd0);
        check("rst_done",   {383'd0, done}, 384'd0);
        check("rst_simo",   {383'd0, SIMO}, 384'd0);
        check("rst_result", {256'd0, result}, 384'd0);
        check("rst_size",   {382'd0, size}, 384'd0);
        reset = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_xfer("ser128", MSG_A, K128, 2'b00, RES_A, 0);
        run_xfer("e2e192", MSG_B, K192, 2'b01, RES_B, 0);
        run_xfer("e2e256", MSG_B, K256, 2'b10, RES_C, 0);
        // Busy guard, also using the unchecked size code 11.
        run_xfer("guard",  MSG_B, K256, 2'b11, RES_C, 11);

        // Reset in the middle of WAIT.
        @(negedge clk);
        msg = MSG_B; key = K192; size_in = 2'b01; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (FRAME + 10) @(posedge clk);
        #1;
        check("midwait_mode", {383'd0, mode}, 384'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_css",    {383'd0, CSS},  384'd1);
        check("midrst_mode",   {383'd0, mode}, 384'd0);
        check("midrst_busy",   {383'd0, busy}, 384'd0);
        check("midrst_result", {256'd0, result}, 384'd0);
        check("midrst_size",   {382'd0, size}, 384'd0);

        run_xfer("after_rst", MSG_B, K192, 2'b01, RES_B, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
